// File: rtl/fifo_sync_pro_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_sync_pro_if : data, request, threshold and status bundle            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fifo_sync_pro_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic [DW-1:0] din;
    logic          wr_en;
    logic          rd_en;
    logic [AW:0]   prog_full_thr;
    logic [AW:0]   prog_empty_thr;
    logic [DW-1:0] dout;
    logic          valid;
    logic [AW:0]   count;
    logic          empty;
    logic          alempty;
    logic          progempty;
    logic          full;
    logic          alfull;
    logic          progfull;
    logic          overflow;
    logic          underflow;

    modport master (
        output din, wr_en, rd_en, prog_full_thr, prog_empty_thr,
        input  dout, valid, count, empty, alempty, progempty,
               full, alfull, progfull, overflow, underflow
    );

    modport slave (
        input  din, wr_en, rd_en, prog_full_thr, prog_empty_thr,
        output dout, valid, count, empty, alempty, progempty,
               full, alfull, progfull, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_pro.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_sync_pro : single-clock FIFO, FWFT/standard read, programmable flags |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fifo_sync_pro #(
    parameter int DW   = 8,
    parameter int AW   = 8,
    parameter bit FWFT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_sync_pro_if.slave  bus
);
    localparam int          DEPTH    = 2**AW;
    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;
    logic          r_empty, r_alempty, r_progempty;
    logic          r_full, r_alfull, r_progfull;
    logic          r_overflow, r_underflow;
    logic          w_wa, w_ra;
    logic [DW-1:0] w_rd_data;

    assign w_wa      = bus.wr_en & ~r_full;
    assign w_ra      = bus.rd_en & ~r_empty;
    assign w_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_comb begin
        w_count_next = r_count;
        if (w_wa && !w_ra) begin
            w_count_next = r_count + ONE;
        end else if (!w_wa && w_ra) begin
            w_count_next = r_count - ONE;
        end
    end

    // Flags come from the next count so they always agree with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_alempty   <= 1'b1;
            r_progempty <= 1'b1;
            r_full      <= 1'b0;
            r_alfull    <= 1'b0;
            r_progfull  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wa) r_wr_ptr <= r_wr_ptr + ONE;
            if (w_ra) r_rd_ptr <= r_rd_ptr + ONE;
            r_count     <= w_count_next;
            r_empty     <= (w_count_next == '0);
            r_alempty   <= (w_count_next <= ONE);
            r_progempty <= (w_count_next <= bus.prog_empty_thr);
            r_full      <= (w_count_next == DEPTH_W);
            r_alfull    <= (w_count_next >= DEPTH_M1);
            r_progfull  <= (w_count_next >= bus.prog_full_thr);
            r_overflow  <= bus.wr_en & r_full;
            r_underflow <= bus.rd_en & r_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wa) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.din;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.dout  = r_empty ? '0 : w_rd_data;
            assign bus.valid = ~r_empty;
        end else begin : g_std
            logic [DW-1:0] r_dout;
            logic          r_valid;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_ra;
                    if (w_ra) r_dout <= w_rd_data;
                end
            end
            assign bus.dout  = r_dout;
            assign bus.valid = r_valid;
        end
    endgenerate

    assign bus.count     = r_count;
    assign bus.empty     = r_empty;
    assign bus.alempty   = r_alempty;
    assign bus.progempty = r_progempty;
    assign bus.full      = r_full;
    assign bus.alfull    = r_alfull;
    assign bus.progfull  = r_progfull;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_pro.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_sync_pro : three FIFO variants driven in lock-step vs queue model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fifo_sync_pro;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [4:0] pft = 5'd3;
    logic [4:0] pet = 5'd1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Variant 0: AW=2 FWFT, 1: AW=2 standard, 2: AW=4 FWFT.
    fifo_sync_pro_if #(.DW(8), .AW(2)) bus_a ();
    fifo_sync_pro_if #(.DW(8), .AW(2)) bus_b ();
    fifo_sync_pro_if #(.DW(8), .AW(4)) bus_c ();

    fifo_sync_pro #(.DW(8), .AW(2), .FWFT(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    fifo_sync_pro #(.DW(8), .AW(2), .FWFT(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    fifo_sync_pro #(.DW(8), .AW(4), .FWFT(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    assign bus_a.din = din;  assign bus_b.din = din;  assign bus_c.din = din;
    assign bus_a.wr_en = wr_en;  assign bus_b.wr_en = wr_en;  assign bus_c.wr_en = wr_en;
    assign bus_a.rd_en = rd_en;  assign bus_b.rd_en = rd_en;  assign bus_c.rd_en = rd_en;
    assign bus_a.prog_full_thr  = pft[2:0];
    assign bus_b.prog_full_thr  = pft[2:0];
    assign bus_c.prog_full_thr  = pft;
    assign bus_a.prog_empty_thr = pet[2:0];
    assign bus_b.prog_empty_thr = pet[2:0];
    assign bus_c.prog_empty_thr = pet;

    logic [7:0] o_dout [3];
    logic [4:0] o_count [3];
    logic       o_valid [3], o_empty [3], o_alempty [3], o_progempty [3];
    logic       o_full [3], o_alfull [3], o_progfull [3], o_ovf [3], o_unf [3];

    assign o_dout[0] = bus_a.dout;  assign o_dout[1] = bus_b.dout;  assign o_dout[2] = bus_c.dout;
    assign o_count[0] = {2'b00, bus_a.count};
    assign o_count[1] = {2'b00, bus_b.count};
    assign o_count[2] = bus_c.count;
    assign o_valid[0] = bus_a.valid;  assign o_valid[1] = bus_b.valid;  assign o_valid[2] = bus_c.valid;
    assign o_empty[0] = bus_a.empty;  assign o_empty[1] = bus_b.empty;  assign o_empty[2] = bus_c.empty;
    assign o_alempty[0] = bus_a.alempty;  assign o_alempty[1] = bus_b.alempty;  assign o_alempty[2] = bus_c.alempty;
    assign o_progempty[0] = bus_a.progempty;  assign o_progempty[1] = bus_b.progempty;  assign o_progempty[2] = bus_c.progempty;
    assign o_full[0] = bus_a.full;  assign o_full[1] = bus_b.full;  assign o_full[2] = bus_c.full;
    assign o_alfull[0] = bus_a.alfull;  assign o_alfull[1] = bus_b.alfull;  assign o_alfull[2] = bus_c.alfull;
    assign o_progfull[0] = bus_a.progfull;  assign o_progfull[1] = bus_b.progfull;  assign o_progfull[2] = bus_c.progfull;
    assign o_ovf[0] = bus_a.overflow;  assign o_ovf[1] = bus_b.overflow;  assign o_ovf[2] = bus_c.overflow;
    assign o_unf[0] = bus_a.underflow;  assign o_unf[1] = bus_b.underflow;  assign o_unf[2] = bus_c.underflow;

    // Reference model: one queue per variant plus the expected outputs.
    int         dep [3] = '{4, 4, 16};
    bit         fw  [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] q [3][$];
    logic [7:0] e_dout [3] = '{8'h00, 8'h00, 8'h00};
    logic [4:0] e_count [3];
    logic       e_valid [3], e_ovf [3], e_unf [3], e_pf [3], e_pe [3];
    bit         e_pf_ok [3], e_pe_ok [3];

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        int sz;
        logic [7:0] popped;
        for (int k = 0; k < 3; k++) begin
            sz = q[k].size();
            e_ovf[k] = w && (sz == dep[k]);
            e_unf[k] = r && (sz == 0);
            if (!fw[k]) e_valid[k] = r && (sz != 0);
            if (r && sz != 0) begin
                popped = q[k].pop_front();
                if (!fw[k]) e_dout[k] = popped;
            end
            if (w && sz != dep[k]) q[k].push_back(d);
            sz = q[k].size();
            e_count[k] = 5'(sz);
            if (fw[k]) begin
                e_valid[k] = (sz != 0);
                e_dout[k]  = (sz != 0) ? q[k][0] : 8'h00;
            end
            e_pf_ok[k] = (pft >= 1) && (pft <= dep[k]);
            e_pe_ok[k] = (pet <= dep[k] - 1);
            e_pf[k]    = (sz >= pft);
            e_pe[k]    = (sz <= pet);
        end
        wr_en = w; rd_en = r; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            e_dout[k] = 8'h00;
        end
    endtask

    task automatic drain();
        repeat (18) step(1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_reset();
        logic [22:0] got;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            got = {o_count[k], o_empty[k], o_alempty[k], o_progempty[k], o_full[k], o_alfull[k],
                   o_progfull[k], o_ovf[k], o_unf[k], o_valid[k], o_dout[k]};
            checks++;
            if (got !== {5'd0, 3'b111, 3'b000, 2'b00, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset dut%0d: got %h want %h", k, got, {5'd0, 3'b111, 6'b0, 9'h000});
            end
        end
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_fill_overflow();
        pft = 5'd3; pet = 5'd1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'(8'h11 * (i + 1)));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (o_count[k] !== e_count[k] || o_alfull[k] !== (e_count[k] >= 5'(dep[k] - 1))
                    || o_full[k] !== (e_count[k] == 5'(dep[k]))) begin
                    errors++;
                    $display("FAIL fill dut%0d: count %0d alfull %b full %b want count %0d", k,
                             o_count[k], o_alfull[k], o_full[k], e_count[k]);
                end
            end
        end
        checks++;
        if (o_count[0] !== 5'd4 || o_full[0] !== 1'b1 || o_dout[0] !== 8'h11) begin
            errors++;
            $display("FAIL fill_end: count %0d full %b dout %h want 4 1 11", o_count[0], o_full[0], o_dout[0]);
        end
        step(1'b1, 1'b0, 8'h55);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_ovf[k] !== e_ovf[k] || o_count[k] !== e_count[k]) begin
                errors++;
                $display("FAIL overflow dut%0d: ovf %b count %0d want %b %0d", k, o_ovf[k], o_count[k], e_ovf[k], e_count[k]);
            end
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (o_ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pulse: ovf %b want 0", o_ovf[0]);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h00);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (o_dout[k] !== e_dout[k] || o_valid[k] !== e_valid[k]) begin
                    errors++;
                    $display("FAIL readout dut%0d: dout %h valid %b want %h %b", k, o_dout[k], o_valid[k], e_dout[k], e_valid[k]);
                end
            end
        end
        checks++;
        if (o_empty[0] !== 1'b1 || o_dout[0] !== 8'h00 || o_dout[1] !== 8'h44) begin
            errors++;
            $display("FAIL drained: empty %b dout0 %h dout1 %h want 1 00 44", o_empty[0], o_dout[0], o_dout[1]);
        end
    endtask

    task automatic test_full_rw();
        while (q[0].size() < 4) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'h66);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_count[k] !== e_count[k] || o_ovf[k] !== e_ovf[k] || o_full[k] !== (e_count[k] == 5'(dep[k]))) begin
                errors++;
                $display("FAIL full_rw dut%0d: count %0d ovf %b full %b want %0d %b", k, o_count[k], o_ovf[k], o_full[k], e_count[k], e_ovf[k]);
            end
        end
        checks++;
        if (o_count[0] !== 5'd3 || o_ovf[0] !== 1'b1 || o_full[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_rw_a: count %0d ovf %b full %b want 3 1 0", o_count[0], o_ovf[0], o_full[0]);
        end
    endtask

    task automatic test_underflow();
        drain();
        step(1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_unf[k] !== 1'b1 || o_count[k] !== 5'd0) begin
                errors++;
                $display("FAIL underflow dut%0d: unf %b count %0d want 1 0", k, o_unf[k], o_count[k]);
            end
        end
        step(1'b1, 1'b1, 8'hA5);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_unf[k] !== e_unf[k] || o_count[k] !== 5'd1 || o_dout[k] !== e_dout[k] || o_valid[k] !== e_valid[k]) begin
                errors++;
                $display("FAIL empty_rw dut%0d: unf %b count %0d dout %h want %b 1 %h", k, o_unf[k], o_count[k], o_dout[k], e_unf[k], e_dout[k]);
            end
        end
        checks++;
        if (o_dout[0] !== 8'hA5) begin
            errors++;
            $display("FAIL empty_rw_fwft: dout %h want a5", o_dout[0]);
        end
    endtask

    task automatic test_std_read();
        drain();
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, (i < 2), 8'h00);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (o_dout[k] !== e_dout[k] || o_valid[k] !== e_valid[k]) begin
                    errors++;
                    $display("FAIL std_read%0d dut%0d: dout %h valid %b want %h %b", i, k, o_dout[k], o_valid[k], e_dout[k], e_valid[k]);
                end
            end
        end
        checks++;
        if (o_dout[1] !== 8'h02 || o_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL std_hold: dout %h valid %b want 02 0", o_dout[1], o_valid[1]);
        end
    endtask

    task automatic test_prog_thresholds();
        drain();
        pft = 5'd10; pet = 5'd3;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'(i));
            for (int k = 0; k < 3; k++) begin
                if (e_pf_ok[k]) begin
                    checks++;
                    if (o_progfull[k] !== e_pf[k]) begin
                        errors++;
                        $display("FAIL progfull dut%0d: got %b want %b", k, o_progfull[k], e_pf[k]);
                    end
                end
            end
        end
        checks++;
        if (o_progfull[2] !== 1'b1 || o_count[2] !== 5'd10) begin
            errors++;
            $display("FAIL progfull_10: progfull %b count %0d want 1 10", o_progfull[2], o_count[2]);
        end
        pft = 5'd12;
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (o_progfull[2] !== 1'b0) begin
            errors++;
            $display("FAIL progfull_thr12: got %b want 0", o_progfull[2]);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 8'h00);
            for (int k = 0; k < 3; k++) begin
                if (e_pe_ok[k]) begin
                    checks++;
                    if (o_progempty[k] !== e_pe[k]) begin
                        errors++;
                        $display("FAIL progempty dut%0d: got %b want %b", k, o_progempty[k], e_pe[k]);
                    end
                end
            end
        end
        checks++;
        if (o_progempty[2] !== 1'b1 || o_count[2] !== 5'd3) begin
            errors++;
            $display("FAIL progempty_3: progempty %b count %0d want 1 3", o_progempty[2], o_count[2]);
        end
    endtask

    task automatic stream(input int n, input logic [7:0] base);
        step(1'b1, 1'b0, base);
        step(1'b1, 1'b0, 8'(base + 1));
        for (int i = 2; i < n + 2; i++) begin
            step(1'b1, 1'b1, 8'(base + i));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (o_dout[k] !== e_dout[k] || o_count[k] !== 5'd2 || o_valid[k] !== e_valid[k]) begin
                    errors++;
                    $display("FAIL stream dut%0d: dout %h count %0d want %h 2", k, o_dout[k], o_count[k], e_dout[k]);
                end
            end
        end
    endtask

    task automatic test_stream_reset();
        logic [22:0] got;
        drain();
        pft = 5'd4; pet = 5'd1;
        stream(48, 8'h80);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            got = {o_count[k], o_empty[k], o_alempty[k], o_progempty[k], o_full[k], o_alfull[k],
                   o_progfull[k], o_ovf[k], o_unf[k], o_valid[k], o_dout[k]};
            checks++;
            if (got !== {5'd0, 3'b111, 3'b000, 2'b00, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL async_reset dut%0d: got %h", k, got);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        stream(20, 8'h30);
    endtask

    task automatic test_random();
        int bias_w, bias_r;
        bias_w = 50; bias_r = 50;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                bias_w = $urandom_range(20, 80);
                bias_r = $urandom_range(20, 80);
            end
            if (i % 37 == 0) begin
                pft = 5'($urandom_range(0, 17));
                pet = 5'($urandom_range(0, 17));
            end
            step($urandom_range(0, 99) < bias_w, $urandom_range(0, 99) < bias_r, 8'($urandom));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (o_count[k] !== e_count[k] || o_dout[k] !== e_dout[k] || o_valid[k] !== e_valid[k]
                    || o_ovf[k] !== e_ovf[k] || o_unf[k] !== e_unf[k]
                    || o_empty[k] !== (e_count[k] == 5'd0) || o_alempty[k] !== (e_count[k] <= 5'd1)
                    || o_full[k] !== (e_count[k] == 5'(dep[k])) || o_alfull[k] !== (e_count[k] >= 5'(dep[k] - 1))) begin
                    errors++;
                    $display("FAIL random%0d dut%0d: count %0d dout %h valid %b ovf %b unf %b e/ae/f/af %b%b%b%b want count %0d dout %h valid %b ovf %b unf %b",
                             i, k, o_count[k], o_dout[k], o_valid[k], o_ovf[k], o_unf[k], o_empty[k], o_alempty[k],
                             o_full[k], o_alfull[k], e_count[k], e_dout[k], e_valid[k], e_ovf[k], e_unf[k]);
                end
                if (e_pf_ok[k]) begin
                    checks++;
                    if (o_progfull[k] !== e_pf[k]) begin
                        errors++;
                        $display("FAIL random_pf%0d dut%0d: got %b want %b", i, k, o_progfull[k], e_pf[k]);
                    end
                end
                if (e_pe_ok[k]) begin
                    checks++;
                    if (o_progempty[k] !== e_pe[k]) begin
                        errors++;
                        $display("FAIL random_pe%0d dut%0d: got %b want %b", i, k, o_progempty[k], e_pe[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_full_rw();
        test_underflow();
        test_std_read();
        test_prog_thresholds();
        test_stream_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
